// File: rtl/regfile_dbg_master.sv
// Debug/test sequencer for the integer register file: turns host read, write,
// clear-all and dump-all requests into write-port / read-port-1 cycles.
module regfile_dbg_master #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy,
    output logic [ADDR_W-1:0] rf_A1,
    input  logic [DATA_W-1:0] rf_RD1,
    output logic [ADDR_W-1:0] rf_A3,
    output logic [DATA_W-1:0] rf_WD3,
    output logic              rf_WE3
);

    typedef enum logic [2:0] {IDLE, RD, WR, CLR, DRD, RSP} state_t;
    typedef enum logic [1:0] {OP_RD = 2'b00, OP_WR = 2'b01, OP_CLR = 2'b10, OP_DUMP = 2'b11} op_t;

    // Index is one bit wider than an address so the last-register compare never aliases.
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NREGS - 1);
    localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W+1)'(1);

    state_t              state;
    op_t                 op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [ADDR_W:0]     idx;

    // NOTE: every register here is sequential state, so all assignments are
    // non-blocking; blocking ones would make later statements see new values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            op_q      <= OP_RD;
            addr_q    <= '0;
            wdata_q   <= '0;
            idx       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            busy      <= 1'b0;
            rf_A1     <= '0;
            rf_A3     <= '0;
            rf_WD3    <= '0;
            rf_WE3    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        op_q      <= op_t'(req_op);
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        case (op_t'(req_op))
                            OP_RD: begin
                                rf_A1 <= req_addr;
                                state <= RD;
                            end
                            OP_WR: begin
                                rf_A3  <= req_addr;
                                rf_WD3 <= req_wdata;
                                rf_WE3 <= (req_addr != '0);
                                state  <= WR;
                            end
                            OP_CLR: begin
                                idx    <= IDX_ONE;
                                rf_A3  <= ADDR_W'(1);
                                rf_WD3 <= '0;
                                rf_WE3 <= 1'b1;
                                state  <= CLR;
                            end
                            default: begin
                                idx   <= '0;
                                rf_A1 <= '0;
                                state <= DRD;
                            end
                        endcase
                    end
                end

                RD: begin
                    rsp_data  <= rf_RD1;
                    rsp_addr  <= addr_q;
                    rsp_last  <= 1'b1;
                    rsp_valid <= 1'b1;
                    state     <= RSP;
                end

                WR: begin
                    rf_WE3    <= 1'b0;
                    rsp_data  <= (addr_q != '0) ? wdata_q : '0;
                    rsp_addr  <= addr_q;
                    rsp_last  <= 1'b1;
                    rsp_valid <= 1'b1;
                    state     <= RSP;
                end

                CLR: begin
                    if (idx == LAST_IDX) begin
                        rf_WE3    <= 1'b0;
                        rsp_addr  <= '0;
                        rsp_data  <= '0;
                        rsp_last  <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end else begin
                        idx   <= idx + IDX_ONE;
                        rf_A3 <= ADDR_W'(idx + IDX_ONE);
                    end
                end

                DRD: begin
                    rsp_data  <= rf_RD1;
                    rsp_addr  <= ADDR_W'(idx);
                    rsp_last  <= (idx == LAST_IDX);
                    rsp_valid <= 1'b1;
                    state     <= RSP;
                end

                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (op_q == OP_DUMP && !rsp_last) begin
                            idx   <= idx + IDX_ONE;
                            rf_A1 <= ADDR_W'(idx + IDX_ONE);
                            state <= DRD;
                        end else begin
                            req_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dbg_master.sv
// Self-checking bench for regfile_dbg_master with a behavioural register file
// (x0 hardwired to zero, combinational read, write on rising clk).
module tb_regfile_dbg_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [4:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [4:0]  rsp_addr;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        busy;
    logic [4:0]  rf_A1;
    logic [31:0] rf_RD1;
    logic [4:0]  rf_A3;
    logic [31:0] rf_WD3;
    logic        rf_WE3;

    localparam logic [1:0] OP_RD = 2'b00, OP_WR = 2'b01, OP_CLR = 2'b10, OP_DUMP = 2'b11;

    regfile_dbg_master #(.ADDR_W(5), .DATA_W(32), .NREGS(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
        .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy),
        .rf_A1(rf_A1), .rf_RD1(rf_RD1), .rf_A3(rf_A3), .rf_WD3(rf_WD3), .rf_WE3(rf_WE3)
    );

    always #5 clk = ~clk;

    logic [31:0] regs [32] = '{default: 32'h0};
    always @(posedge clk) if (rf_WE3 && rf_A3 != 5'd0) regs[rf_A3] <= rf_WD3;
    assign rf_RD1 = (rf_A1 == 5'd0) ? 32'h0 : regs[rf_A1];

    int we_cnt = 0;
    int we0_cnt = 0;
    always @(posedge clk) begin
        if (rf_WE3) we_cnt <= we_cnt + 1;
        if (rf_WE3 && rf_A3 == 5'd0) we0_cnt <= we0_cnt + 1;
    end

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_regs [32];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // All tasks start and end at a falling edge.
    task automatic send(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
        int n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", 96'(req_ready), 96'(1'b1));
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int start, output int lat);
        int n = start;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rsp_wait", 96'(rsp_valid), 96'(1'b1));
        lat = n;
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic do_op(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d,
                         output logic [31:0] data, output logic [4:0] raddr, output logic last,
                         output int lat, output logic we1, output logic [4:0] a1,
                         output logic [4:0] a3, output logic [31:0] wd3);
        send(op, a, d);
        we1 = rf_WE3; a1 = rf_A1; a3 = rf_A3; wd3 = rf_WD3;
        wait_rsp(1, lat);
        data = rsp_data; raddr = rsp_addr; last = rsp_last;
        ack();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        logic [31:0] data, wd3;
        logic [4:0]  raddr, a1, a3;
        logic        last, we1;
        int          lat;
        do_op(OP_WR, a, d, data, raddr, last, lat, we1, a1, a3, wd3);
    endtask

    task automatic rd_check(input string name, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] data, wd3;
        logic [4:0]  raddr, a1, a3;
        logic        last, we1;
        int          lat;
        do_op(OP_RD, a, 32'h0, data, raddr, last, lat, we1, a1, a3, wd3);
        check(name, 96'(data), 96'(exp));
    endtask

    task automatic do_dump();
        int lat;
        send(OP_DUMP, 5'd0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            wait_rsp(0, lat);
            check($sformatf("dump_rsp[%0d]", i), 96'({rsp_addr, rsp_data, rsp_last}),
                  96'({i[4:0], exp_regs[i], (i == 31)}));
            if (i % 2 == 1) begin
                @(negedge clk);
                check($sformatf("dump_hold[%0d]", i), 96'({rsp_valid, rsp_addr, rsp_data, rsp_last}),
                      96'({1'b1, i[4:0], exp_regs[i], (i == 31)}));
            end
            ack();
        end
        repeat (3) @(negedge clk);
        check("dump_end", 96'({rsp_valid, req_ready, busy}), 96'(3'b010));
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_we;
    } vec_t;

    vec_t vecs [10];

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish, required finish before 600000");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] data, wd3;
        logic [4:0]  raddr, a1, a3;
        logic        last, we1;
        int          lat, n, we_start;
        logic [4:0]  exp_a;

        vecs[0] = '{OP_WR, 5'd1,  32'h12345678, 32'h12345678, 1'b1};
        vecs[1] = '{OP_RD, 5'd1,  32'h0,        32'h12345678, 1'b0};
        vecs[2] = '{OP_WR, 5'd0,  32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[3] = '{OP_RD, 5'd0,  32'h0,        32'h00000000, 1'b0};
        vecs[4] = '{OP_WR, 5'd2,  32'h87654321, 32'h87654321, 1'b1};
        vecs[5] = '{OP_WR, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
        vecs[6] = '{OP_RD, 5'd2,  32'h0,        32'h87654321, 1'b0};
        vecs[7] = '{OP_RD, 5'd31, 32'h0,        32'hFFFFFFFF, 1'b0};
        vecs[8] = '{OP_WR, 5'd5,  32'h00000000, 32'h00000000, 1'b1};
        vecs[9] = '{OP_RD, 5'd5,  32'h0,        32'h00000000, 1'b0};

        // Reset state.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 96'({req_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, busy,
                                    rf_A1, rf_A3, rf_WD3, rf_WE3}), 96'(0));
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_idle", 96'({req_ready, busy, rsp_valid}), 96'(3'b100));

        // Single reads and writes.
        for (int v = 0; v < 10; v++) begin
            do_op(vecs[v].op, vecs[v].addr, vecs[v].wdata, data, raddr, last, lat, we1, a1, a3, wd3);
            check($sformatf("v%0d_data", v), 96'(data), 96'(vecs[v].exp_data));
            check($sformatf("v%0d_last", v), 96'(last), 96'(1'b1));
            check($sformatf("v%0d_latency", v), 96'(lat), 96'(2));
            check($sformatf("v%0d_we", v), 96'(we1), 96'(vecs[v].exp_we));
            if (vecs[v].op == OP_RD)
                check($sformatf("v%0d_rd_addr", v), 96'({a1, raddr}), 96'({vecs[v].addr, vecs[v].addr}));
            else if (vecs[v].exp_we)
                check($sformatf("v%0d_wr_port", v), 96'({a3, wd3}), 96'({vecs[v].addr, vecs[v].wdata}));
            check($sformatf("v%0d_rsp_drop", v), 96'(rsp_valid), 96'(1'b0));
        end
        check("x0_never_written", 96'(we0_cnt), 96'(0));

        // Read with a stalled host: response holds, no new request accepted.
        send(OP_RD, 5'd1, 32'h0);
        wait_rsp(1, lat);
        check("stall_latency", 96'(lat), 96'(2));
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall_hold[%0d]", k),
                  96'({rsp_valid, rsp_data, rsp_addr, rsp_last, req_ready}),
                  96'({1'b1, 32'h12345678, 5'd1, 1'b1, 1'b0}));
            @(negedge clk);
        end
        ack();
        check("stall_release", 96'({rsp_valid, req_ready}), 96'(2'b01));

        // Clear-all: x2 and x31 hold nonzero values from the vectors above.
        we_start = we_cnt;
        send(OP_CLR, 5'd0, 32'h0);
        check("clr_busy", 96'(busy), 96'(1'b1));
        exp_a = 5'd1;
        n = 1;
        while (!rsp_valid && n < 100) begin
            if (rf_WE3) begin
                check($sformatf("clr_wr[%0d]", exp_a), 96'({rf_A3, rf_WD3}), 96'({exp_a, 32'h0}));
                exp_a++;
            end
            @(negedge clk);
            n++;
        end
        check("clr_latency", 96'(n), 96'(32));
        check("clr_write_count", 96'(we_cnt - we_start), 96'(31));
        check("clr_ack", 96'({rsp_valid, rsp_addr, rsp_data, rsp_last}), 96'({1'b1, 5'd0, 32'h0, 1'b1}));
        ack();
        rd_check("clr_x2", 5'd2, 32'h0);
        rd_check("clr_x31", 5'd31, 32'h0);

        // Dump of a patterned file with a host that stalls on every other response.
        exp_regs[0] = 32'h0;
        for (int i = 1; i < 32; i++) begin
            wr(i[4:0], 32'(i * 17));
            exp_regs[i] = 32'(i * 17);
        end
        do_dump();

        // Reset in the middle of a clear, right as x10 is being written.
        for (int i = 1; i < 32; i++) wr(i[4:0], 32'hA5A5A5A5);
        send(OP_CLR, 5'd0, 32'h0);
        n = 0;
        while (!(rf_WE3 && rf_A3 == 5'd10) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach_x10", 96'({rf_WE3, rf_A3}), 96'({1'b1, 5'd10}));
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_outputs", 96'({req_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, busy,
                                    rf_A1, rf_A3, rf_WD3, rf_WE3}), 96'(0));
        rst = 1'b1;
        @(negedge clk);
        check("abort_idle", 96'({req_ready, busy, rsp_valid}), 96'(3'b100));
        for (int i = 0; i < 32; i++) exp_regs[i] = (i <= 10) ? 32'h0 : 32'hA5A5A5A5;
        do_dump();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
